// File: rtl/gate_truth_table_checker_if.sv
// Bundle between the truth-table checker and its environment: start request and
// gate response in, gate stimulus and run status out.
// Optional GTC_ERRCNT_EN adds the saturating err_count field.
interface gate_truth_table_checker_if;
   logic       start;
   logic       y_in;
   logic       a_out;
   logic       b_out;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] table_out;
`ifdef GTC_ERRCNT_EN
   logic [7:0] err_count;

   // Environment side: requests runs and returns the gate output.
   modport master (
      output start, y_in,
      input  a_out, b_out, busy, done, pass, table_out, err_count
   );

   // Checker side.
   modport slave (
      input  start, y_in,
      output a_out, b_out, busy, done, pass, table_out, err_count
   );
`else
   // Environment side: requests runs and returns the gate output.
   modport master (
      output start, y_in,
      input  a_out, b_out, busy, done, pass, table_out
   );

   // Checker side.
   modport slave (
      input  start, y_in,
      output a_out, b_out, busy, done, pass, table_out
   );
`endif
endinterface

// File: rtl/gate_truth_table_checker.sv
// Self-test stage for a 2-input gate: steps a/b through 00,01,10,11, waits
// SETTLE_CYCLES per vector, samples y_in into a truth table and compares it
// against EXPECTED. Optional feature macro: GTC_ERRCNT_EN (saturating
// count of failing runs on bus.err_count).
module gate_truth_table_checker #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [3:0]  EXPECTED      = 4'b0111
) (
   input logic                       clk,
   input logic                       rst,
   gate_truth_table_checker_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

   localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);

   state_e     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] table_q, table_d;
   logic       pass_q, pass_d;
   logic       busy_q, busy_d;
   logic       table_match;

   // Final table includes the vector-3 sample taken on this very edge.
   assign table_match = ({bus.y_in, table_q[2:0]} == EXPECTED);

   // Next-state and datapath decode.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      table_d = table_q;
      pass_d  = pass_q;
      busy_d  = busy_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               idx_d   = 2'd0;
               cnt_d   = 8'd0;
               table_d = 4'd0;
               pass_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = StSettle;
            end
         end
         StSettle: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == SettleLast) begin
               state_d = StSample;
            end
         end
         StSample: begin
            table_d[idx_q] = bus.y_in;
            if (idx_q != 2'd3) begin
               // a/b follow idx, so the next vector appears on this edge.
               idx_d   = idx_q + 2'd1;
               cnt_d   = 8'd0;
               state_d = StSettle;
            end else begin
               pass_d  = table_match;
               busy_d  = 1'b0;
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= 2'd0;
         cnt_q   <= 8'd0;
         table_q <= 4'd0;
         pass_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         table_q <= table_d;
         pass_q  <= pass_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.a_out     = idx_q[1];
   assign bus.b_out     = idx_q[0];
   assign bus.busy      = busy_q;
   assign bus.done      = (state_q == StDone);
   assign bus.pass      = pass_q;
   assign bus.table_out = table_q;

`ifdef GTC_ERRCNT_EN
   logic [7:0] err_q, err_d;

   // Count failing runs at DONE entry; saturate instead of wrapping.
   always_comb begin
      err_d = err_q;
      if ((state_q == StSample) && (idx_q == 2'd3) && !table_match && (err_q != 8'hFF)) begin
         err_d = err_q + 8'd1;
      end
   end

   // Error counter register; only reset clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 8'd0;
      end else begin
         err_q <= err_d;
      end
   end

   assign bus.err_count = err_q;
`endif

endmodule
